stopwatch_bcd_counter: RTL and testbench
========================================

STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, clk cycles per count tick (10 ms at 100 MHz); legal range 2 to 2^24.
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, stable-level cycles required to accept a button change; legal range 2 to 2^20.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port btn_start  input  1  raw asynchronous start/stop pushbutton, active-high.
REQ-006 SHALL have port btn_clear  input  1  raw asynchronous clear pushbutton, active-high.
REQ-007 SHALL have port btn_lap  input  1  raw asynchronous lap pushbutton, active-high; ignored unless STOPWATCH_LAP_EN is defined.
REQ-008 SHALL have port value  output  16  four BCD digits {d3,d2,d1,d0} = SS.hh, for the downstream 4-digit hex-to-7-segment display.
REQ-009 SHALL have port running  output  1  high while in RUN or LAP.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse when the count rolls 59.99 -> 00.00.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates the accepted level only after DEB_CYCLES consecutive identical synchronized samples.
REQ-012 A button event SHALL be a one-cycle pulse on the 0->1 transition of the accepted level; holding a button SHALL produce one event.
REQ-013 Button event latency from raw input edge SHALL be exactly 2 + DEB_CYCLES + 1 cycles for a clean edge.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 only in RUN/LAP, emitting a tick on the terminal value; it SHALL hold in IDLE/PAUSE and zero on clear.
REQ-015 Digit ranges: d0 0-9, d1 0-9, d2 0-9, d3 0-5; each tick increments d0 with BCD carry ripple in the same cycle.
REQ-016 At 59.99 a tick SHALL produce 00.00, pulse wrap for that cycle, and counting SHALL continue.
REQ-017 States: IDLE (count zero, stopped), RUN, PAUSE, LAP (macro only).
REQ-018 IDLE --start--> RUN; RUN --start--> PAUSE; PAUSE --start--> RUN, resuming without prescaler loss.
REQ-019 clear in any state SHALL zero digits and prescaler and go to IDLE on the next edge.
REQ-020 Simultaneous start and clear events: clear SHALL win.
REQ-021 A tick coinciding with a start event that stops the count SHALL still be applied.
REQ-022 value SHALL be registered and SHALL equal the live count except in LAP.
REQ-023 Outputs SHALL change only on clk edges, with no combinational path from any button to any output.

Reset
REQ-024 While reset is low at a clk edge: state SHALL be IDLE, digits and prescaler 0, value 16'h0000, running 0, wrap 0.
REQ-025 Reset SHALL clear synchronizers, debounce counters and accepted levels to 0.
REQ-026 A button held through reset release SHALL generate an event once its accepted level reaches 1.
REQ-027 Reset asserted mid-count SHALL take effect at the next edge regardless of pending ticks or events.

Configuration
REQ-028 Macro STOPWATCH_LAP_EN SHALL control the lap feature.
REQ-029 With STOPWATCH_LAP_EN defined: a lap event in RUN SHALL go to LAP and freeze value at the count of that cycle while counting continues; a lap event in LAP SHALL return to RUN with value live; a start event in LAP SHALL go to PAUSE with value live; lap events in IDLE/PAUSE SHALL be ignored.
REQ-030 Without STOPWATCH_LAP_EN: btn_lap SHALL be unused, LAP state and its logic SHALL not exist, and behaviour SHALL otherwise be identical.

Verification
REQ-031 TICK_DIV=4, DEB_CYCLES=3: reset low 2 cycles, then high; start pulse held 10 cycles -> running=1 after 6 cycles, value 16'h0001 four cycles after the first tick period.
REQ-032 Run 5999 ticks -> value 16'h5999; next tick -> value 16'h0000, wrap high exactly 1 cycle, running stays 1.
REQ-033 Raw btn_start toggling every 2 cycles for 20 cycles, then low -> no event, state unchanged.
REQ-034 At value 16'h0123 press start (PAUSE), wait 100 cycles -> value holds 16'h0123; press start -> resumes to 16'h0124 after the remaining prescaler count.
REQ-035 start and clear asserted together while running -> IDLE, value 16'h0000, running 0.
REQ-036 With STOPWATCH_LAP_EN, lap at 16'h0250, run 50 ticks -> value holds 16'h0250; lap again -> value 16'h0300.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch with four BCD digits (SS.hh), debounced start/clear buttons and
// an optional lap-freeze feature enabled by defining STOPWATCH_LAP_EN.
// All state is reset synchronously by an active-low reset.

// Per-button conditioner: 2-flop synchronizer, level debouncer, rising-edge event.
module stopwatch_btn_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_evt
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_evt;

    // Accept a new level after DEB_CYCLES consecutive differing samples; pulse on 0->1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_evt   <= 1'b0;
            if (r_sync2 == r_acc) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_acc <= r_sync2;
                r_cnt <= '0;
                r_evt <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_evt = r_evt;
endmodule

module stopwatch_bcd_counter #(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] value,
    output logic        running,
    output logic        wrap
);
    localparam int PW = $clog2(TICK_DIV);

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
    logic [NUM_BTN-1:0] w_raw;
    assign w_raw = {btn_lap, btn_clear, btn_start};
`else
    localparam int NUM_BTN = 2;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
    logic [NUM_BTN-1:0] w_raw;
    logic               w_unused_lap;
    assign w_raw        = {btn_clear, btn_start};
    assign w_unused_lap = btn_lap;
`endif

    logic [NUM_BTN-1:0] w_evt;
    logic               w_ev_start;
    logic               w_ev_clear;

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            stopwatch_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .reset (reset),
                .i_btn (w_raw[g]),
                .o_evt (w_evt[g])
            );
        end
    endgenerate

    assign w_ev_start = w_evt[0];
    assign w_ev_clear = w_evt[1];

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_d0, r_d1, r_d2, r_d3;
    logic [15:0]   r_value;
    logic          r_running;
    logic          r_wrap;

    logic          w_cnt_en;
    logic          w_tick;
    logic [3:0]    w_n0, w_n1, w_n2, w_n3;
    logic          w_roll;

`ifdef STOPWATCH_LAP_EN
    assign w_cnt_en = (r_state == S_RUN) || (r_state == S_LAP);
`else
    assign w_cnt_en = (r_state == S_RUN);
`endif
    assign w_tick = w_cnt_en && (r_presc == PW'(TICK_DIV - 1));

    // Next count: one tick increments d0 and ripples BCD carries up to d3 (0-5).
    always_comb begin
        w_n0   = r_d0;
        w_n1   = r_d1;
        w_n2   = r_d2;
        w_n3   = r_d3;
        w_roll = 1'b0;
        if (w_tick) begin
            if (r_d0 != 4'd9) begin
                w_n0 = r_d0 + 4'd1;
            end else begin
                w_n0 = 4'd0;
                if (r_d1 != 4'd9) begin
                    w_n1 = r_d1 + 4'd1;
                end else begin
                    w_n1 = 4'd0;
                    if (r_d2 != 4'd9) begin
                        w_n2 = r_d2 + 4'd1;
                    end else begin
                        w_n2 = 4'd0;
                        if (r_d3 != 4'd5) begin
                            w_n3 = r_d3 + 4'd1;
                        end else begin
                            w_n3   = 4'd0;
                            w_roll = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Control FSM, prescaler, digits and registered outputs; clear beats start.
    always_ff @(posedge clk) begin
        if (!reset || w_ev_clear) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_d0      <= 4'd0;
            r_d1      <= 4'd0;
            r_d2      <= 4'd0;
            r_d3      <= 4'd0;
            r_value   <= 16'h0000;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            // A tick is applied even when the same edge stops the count.
            r_d0    <= w_n0;
            r_d1    <= w_n1;
            r_d2    <= w_n2;
            r_d3    <= w_n3;
            r_wrap  <= w_roll;
            r_value <= {w_n3, w_n2, w_n1, w_n0};
            if (w_cnt_en)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            case (r_state)
                S_IDLE: if (w_ev_start) begin
                    r_state   <= S_RUN;
                    r_running <= 1'b1;
                end
                S_RUN: begin
                    if (w_ev_start) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (w_evt[2]) begin
                        // Freeze the display at the count held before this edge's tick.
                        r_state <= S_LAP;
                        r_value <= {r_d3, r_d2, r_d1, r_d0};
                    end
`endif
                end
                S_PAUSE: if (w_ev_start) begin
                    r_state   <= S_RUN;
                    r_running <= 1'b1;
                end
`ifdef STOPWATCH_LAP_EN
                S_LAP: begin
                    if (w_ev_start) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_evt[2]) begin
                        r_state <= S_RUN;
                    end else begin
                        r_value <= r_value;
                    end
                end
`endif
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign value   = r_value;
    assign running = r_running;
    assign wrap    = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Randomized + directed bench for stopwatch_bcd_counter with a scoreboard fed
// by a count-based reference model (integer ticks, arithmetic BCD).
module tb_stopwatch_bcd_counter;
    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] value;
    logic        running;
    logic        wrap;

    stopwatch_bcd_counter #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .value     (value),
        .running   (running),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] v;
        logic        r;
        logic        w;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model state
    int          m_cnt, m_p, m_st;
    logic [15:0] m_fv, m_val;
    bit          m_run, m_wrap, tick, s;
    bit          h1[3], h2[3], acc[3], ls[3], ev[3], e[3], raw[3];
    int          rl[3];

    function automatic logic [15:0] bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Model: states 0=idle 1=run 2=pause 3=lap; count is ticks mod 6000.
    always @(posedge clk) begin
        cyc++;
        raw[0] = btn_start; raw[1] = btn_clear; raw[2] = btn_lap;
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_p = 0; m_fv = 0; m_wrap = 0;
            for (int b = 0; b < 3; b++) begin
                h1[b] = 0; h2[b] = 0; acc[b] = 0; ls[b] = 0; ev[b] = 0; rl[b] = 0;
            end
        end else begin
            for (int b = 0; b < 3; b++) e[b] = ev[b];
`ifndef STOPWATCH_LAP_EN
            e[2] = 0;
`endif
            for (int b = 0; b < 3; b++) begin
                s = h2[b]; h2[b] = h1[b]; h1[b] = raw[b]; ev[b] = 0;
                if (s == ls[b]) rl[b]++; else rl[b] = 1;
                ls[b] = s;
                if (s != acc[b] && rl[b] >= DB) begin acc[b] = s; ev[b] = s; end
            end
            tick = (m_st == 1 || m_st == 3) && m_p == TD - 1;
            if (e[1]) begin
                m_st = 0; m_cnt = 0; m_p = 0; m_wrap = 0;
            end else begin
                m_wrap = tick && m_cnt == 5999;
                if (m_st == 1 || m_st == 3) m_p = tick ? 0 : m_p + 1;
                if (e[0]) begin
                    m_st = (m_st == 1 || m_st == 3) ? 2 : 1;
                end else if (e[2]) begin
                    if (m_st == 1) begin m_st = 3; m_fv = bcd(m_cnt); end
                    else if (m_st == 3) m_st = 1;
                end
                if (tick) m_cnt = (m_cnt + 1) % 6000;
            end
        end
        m_val = (m_st == 3) ? m_fv : bcd(m_cnt);
        m_run = (m_st == 1 || m_st == 3);
        q.push_back({m_val, m_run, m_wrap});
    end

    // Monitor: every cycle the DUT presents a new output word; compare with the model.
    always @(negedge clk) begin
        exp_t x;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty cyc=%0d no expected entry", cyc);
        end else begin
            x = q.pop_front();
            if ({value, running, wrap} !== x) begin
                bad++;
                $display("FAIL sb cyc=%0d got v=%h r=%b w=%b exp v=%h r=%b w=%b",
                         cyc, value, running, wrap, x.v, x.r, x.w);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_start = v;
            1: btn_clear = v;
            default: btn_lap = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic wait_cnt(input int target, input int budget, input string nm);
        int n = 0;
        while (m_cnt != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != target) begin
            total++; bad++;
            $display("FAIL %s timeout got=%0d exp=%0d", nm, m_cnt, target);
        end
    endtask

    initial begin
        int n;
        // Reset for two edges
        repeat (2) @(negedge clk);
        chk("rst_value", value, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_wrap", {15'd0, wrap}, 16'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Start held 10 cycles: running after 6 edges, first count 4 edges later
        btn_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5)  chk("start_lat_before", {15'd0, running}, 16'd0);
            if (i == 6)  chk("start_lat", {15'd0, running}, 16'd1);
            if (i == 9)  chk("first_tick_before", value, 16'h0000);
            if (i == 10) chk("first_tick", value, 16'h0001);
        end
        btn_start = 1'b0;

        // Count to 59.99 then roll over
        wait_cnt(5999, 30000, "reach_5999");
        chk("val_5999", value, 16'h5999);
        n = 0;
        while (wrap !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        chk("wrap_seen", {15'd0, wrap}, 16'd1);
        chk("wrap_value", value, 16'h0000);
        chk("wrap_running", {15'd0, running}, 16'd1);
        @(negedge clk);
        chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);

        // Bouncing start button: runs of 2 never satisfy the debouncer
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            repeat (2) @(negedge clk);
        end
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_ignored", {15'd0, running}, 16'd1);

        // Clear, run to near 01.23, pause, hold, resume
        press(1, 4);
        chk("clear_value", value, 16'h0000);
        press(0, 4);
        wait_cnt(121, 2000, "reach_0121");
        press(0, 3);
        chk("pause_running", {15'd0, running}, 16'd0);
        repeat (100) @(negedge clk);
        press(0, 3);
        chk("resume_running", {15'd0, running}, 16'd1);
        repeat (20) @(negedge clk);

        // Start and clear together while running: clear wins
        btn_start = 1'b1; btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_start = 1'b0; btn_clear = 1'b0;
        chk("sim_clear_value", value, 16'h0000);
        chk("sim_clear_running", {15'd0, running}, 16'd0);
        repeat (8) @(negedge clk);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze around 02.50
        press(0, 4);
        wait_cnt(244, 3000, "reach_0244");
        press(2, 4);
        repeat (200) @(negedge clk);
        press(2, 4);
        repeat (10) @(negedge clk);
        press(1, 4);
`endif

        // Randomized phase
        for (int it = 0; it < 400; it++) begin
            int act;
            act = $urandom_range(0, 19);
            if (act < 7) begin
                press(0, $urandom_range(1, 8));
            end else if (act < 9) begin
                press(1, $urandom_range(1, 6));
            end else if (act < 12) begin
                press(2, $urandom_range(1, 8));
            end else if (act < 14) begin
                for (int k = 0; k < 8; k++) begin
                    btn_start = $urandom_range(0, 1);
                    @(negedge clk);
                end
                btn_start = 1'b0;
                repeat (DB + 4) @(negedge clk);
            end else if (act == 14) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b1;
            end else if (act == 15) begin
                btn_start = 1'b1; btn_lap = 1'b1;
                repeat (5) @(negedge clk);
                btn_start = 1'b0; btn_lap = 1'b0;
                repeat (DB + 4) @(negedge clk);
            end else begin
                repeat ($urandom_range(1, 60)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
